final_mix_palette: RTL and testbench

Final-video colour stage directly downstream of the sprite-line colour-bank/layer-select decode. Each pixel slot it picks the sprite, background or text colour code using the decoded active-low layer selects. It forms a 10-bit palette index with the decoded colour bank and looks it up in an internal 1024×12 palette RAM shared with the CPU. It emits RGB 4:4:4 with blanking and syncs delay-matched to the pixel.

---
 rtl/final_video_pkg.sv | 54 +++++
 rtl/final_mix_palram.sv | 39 +++
 rtl/final_mix_palette.sv | 194 +++++++++++++++++++
 tb/tb_final_mix_palette.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/final_video_pkg.sv
// -----------------------------------------------------------------------------
// final_video_pkg
// Shared constants and types for the final video colour stage.
//   PAL_AW / RGB_W   : palette address / word widths
//   SEL_SPRITE/SEL_BG: decoded {layer_selb_n, layer_sela_n} codes
//   TRANSP_NIBBLE    : sprite low nibble meaning "transparent"
//   SHADOW_CODE      : sprite code treated as shadow when FINAL_MIX_SHADOW_EN
//   vid_timing_t     : blank/sync bits (plus shadow flag when enabled)
//   pix_stage_t      : pipeline stage record {index, timing}
// Optional feature macro: FINAL_MIX_SHADOW_EN
// -----------------------------------------------------------------------------
package final_video_pkg;

    localparam int PAL_AW = 10;
    localparam int RGB_W  = 12;
    localparam int CODE_W = 7;
    localparam int BANK_W = 3;

    localparam logic [1:0]        SEL_SPRITE    = 2'b00;
    localparam logic [1:0]        SEL_BG        = 2'b11;
    localparam logic [3:0]        TRANSP_NIBBLE = 4'hF;
    localparam logic [CODE_W-1:0] SHADOW_CODE   = 7'h7E;

    typedef enum logic {
        WB_IDLE,
        WB_PEND
    } wbuf_state_t;

    typedef struct packed {
        logic hb;
        logic vb;
        logic hs_n;
        logic vs_n;
`ifdef FINAL_MIX_SHADOW_EN
        logic shadow;
`endif
    } vid_timing_t;

    typedef struct packed {
        logic [PAL_AW-1:0] index;
        vid_timing_t       tm;
    } pix_stage_t;

    // Idle timing: both blanks active, both syncs inactive, no shadow.
    function automatic vid_timing_t timing_idle();
        vid_timing_t t;
        t = '1;
`ifdef FINAL_MIX_SHADOW_EN
        t.shadow = 1'b0;
`endif
        return t;
    endfunction

endpackage

// File: rtl/final_mix_palram.sv
// -----------------------------------------------------------------------------
// final_mix_palram
// Single-port synchronous palette RAM with a read-enable-gated output register.
//   clk  : clock
//   re   : read enable; dout loads mem[addr] only when high
//   we   : write enable; mem[addr] <= din
//   addr : shared read/write address
//   din  : write data
//   dout : registered read data (holds between reads)
// The caller guarantees re and we are never high together.
// -----------------------------------------------------------------------------
module final_mix_palram #(
    parameter int AW = 10,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: no reset here -- a reset term would stop the array mapping onto
    // block RAM, and palette contents are owned by the CPU anyway.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        if (re) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/final_mix_palette.sv
// -----------------------------------------------------------------------------
// final_mix_palette
// Picks sprite/background/text colour code, forms {colbank, code} palette
// index, looks it up in the shared palette RAM and outputs RGB 4:4:4 with
// blank/sync delayed by the same three pixel slots.
//   clk, RESETn                  : clock, async active-low reset
//   pix_ce                       : pixel-slot enable (never on back-to-back)
//   sp_pix, bg_pix, tx_pix       : 7-bit colour codes
//   colbank                      : 3-bit palette bank
//   layer_sela_n, layer_selb_n   : active-low layer selects
//   hblank, vblank, hsync_n, vsync_n : raw timing in
//   cpu_we, cpu_addr, cpu_din    : palette write request (1-clk pulse)
//   cpu_busy                     : write pending; new requests are dropped
//   rgb                          : {R,G,B}, forced to 0 while blanked
//   hblank_o, vblank_o, hsync_no, vsync_no : delay-matched timing out
// Optional feature macro: FINAL_MIX_SHADOW_EN (sprite 7'h7E = shadow pixel)
// -----------------------------------------------------------------------------
module final_mix_palette
    import final_video_pkg::*;
#(
    parameter int PAL_AW = final_video_pkg::PAL_AW,
    parameter int RGB_W  = final_video_pkg::RGB_W
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic              pix_ce,
    input  logic [6:0]        sp_pix,
    input  logic [6:0]        bg_pix,
    input  logic [6:0]        tx_pix,
    input  logic [2:0]        colbank,
    input  logic              layer_sela_n,
    input  logic              layer_selb_n,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              hsync_n,
    input  logic              vsync_n,
    input  logic              cpu_we,
    input  logic [PAL_AW-1:0] cpu_addr,
    input  logic [RGB_W-1:0]  cpu_din,
    output logic              cpu_busy,
    output logic [RGB_W-1:0]  rgb,
    output logic              hblank_o,
    output logic              vblank_o,
    output logic              hsync_no,
    output logic              vsync_no
);

    // ---------------- source select ----------------
    logic [6:0] sel_code;
    logic       sel_shadow;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        sel_code   = tx_pix;
        sel_shadow = 1'b0;
        case ({layer_selb_n, layer_sela_n})
            SEL_SPRITE: begin
                if (sp_pix[3:0] == TRANSP_NIBBLE) begin
                    sel_code = bg_pix;
                end else begin
                    sel_code = sp_pix;
                end
`ifdef FINAL_MIX_SHADOW_EN
                // Shadow pixel shows the background, darkened at S3.
                if (sp_pix == SHADOW_CODE) begin
                    sel_code   = bg_pix;
                    sel_shadow = 1'b1;
                end
`endif
            end
            SEL_BG:  sel_code = bg_pix;
            default: sel_code = tx_pix;
        endcase
    end

    pix_stage_t s1_nxt;

    always_comb begin
        s1_nxt         = '0;
        s1_nxt.index   = {colbank, sel_code};
        s1_nxt.tm.hb   = hblank;
        s1_nxt.tm.vb   = vblank;
        s1_nxt.tm.hs_n = hsync_n;
        s1_nxt.tm.vs_n = vsync_n;
`ifdef FINAL_MIX_SHADOW_EN
        s1_nxt.tm.shadow = sel_shadow;
`endif
    end

    // ---------------- pixel pipeline ----------------
    // S1 holds index+timing, S2 is the RAM read (timing rides in s2),
    // S3 captures RAM data alongside s3 timing.
    pix_stage_t       s1;
    vid_timing_t      s2;
    vid_timing_t      s3;
    logic [RGB_W-1:0] s3_word;
    logic [RGB_W-1:0] ram_dout;

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            s1.index <= '0;
            s1.tm    <= timing_idle();
            s2       <= timing_idle();
            s3       <= timing_idle();
            s3_word  <= '0;
        end else if (pix_ce) begin
            s1      <= s1_nxt;
            s2      <= s1.tm;
            s3      <= s2;
            s3_word <= ram_dout;
        end
    end

    // ---------------- CPU write buffer ----------------
    wbuf_state_t       wb_state, wb_nxt;
    logic [PAL_AW-1:0] wr_addr;
    logic [RGB_W-1:0]  wr_data;
    logic              wr_accept;
    logic              ram_we;

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            wb_state <= WB_IDLE;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wb_state <= wb_nxt;
            if (wr_accept) begin
                wr_addr <= cpu_addr;
                wr_data <= cpu_din;
            end
        end
    end

    always_comb begin
        wb_nxt    = wb_state;
        wr_accept = 1'b0;
        ram_we    = 1'b0;
        case (wb_state)
            WB_IDLE: begin
                if (cpu_we) begin
                    wr_accept = 1'b1;
                    wb_nxt    = WB_PEND;
                end
            end
            WB_PEND: begin
                // Commit only in a slot with no pixel read on the port.
                if (!pix_ce) begin
                    ram_we = 1'b1;
                    wb_nxt = WB_IDLE;
                end
            end
            default: wb_nxt = WB_IDLE;
        endcase
    end

    assign cpu_busy = (wb_state == WB_PEND);

    // ---------------- palette RAM ----------------
    logic [PAL_AW-1:0] ram_addr;
    assign ram_addr = pix_ce ? s1.index : wr_addr;

    final_mix_palram #(
        .AW (PAL_AW),
        .DW (RGB_W)
    ) u_palram (
        .clk  (clk),
        .re   (pix_ce),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (wr_data),
        .dout (ram_dout)
    );

    // ---------------- output ----------------
    logic [RGB_W-1:0] pix_word;

    always_comb begin
        pix_word = s3_word;
`ifdef FINAL_MIX_SHADOW_EN
        if (s3.shadow) begin
            pix_word = {1'b0, s3_word[11:9], 1'b0, s3_word[7:5], 1'b0, s3_word[3:1]};
        end
`endif
        rgb = (s3.hb || s3.vb) ? '0 : pix_word;
    end

    assign hblank_o = s3.hb;
    assign vblank_o = s3.vb;
    assign hsync_no = s3.hs_n;
    assign vsync_no = s3.vs_n;

endmodule

// File: tb/tb_final_mix_palette.sv
// -----------------------------------------------------------------------------
// tb_final_mix_palette
// Self-checking bench for final_mix_palette. Pixel vectors carry hand-derived
// expected outputs; each is queued when driven and compared when it reaches
// the output three pix_ce edges later. Hand sequences cover write-buffer
// timing, read/write ordering on one address and reset during a pending write.
// -----------------------------------------------------------------------------
module tb_final_mix_palette;

    typedef struct {
        logic [6:0]  sp;
        logic [6:0]  bg;
        logic [6:0]  tx;
        logic [2:0]  bank;
        logic        selb_n;
        logic        sela_n;
        logic        hb;
        logic        vb;
        logic        hs_n;
        logic        vs_n;
        logic [11:0] exp_rgb;
    } vec_t;

    typedef struct {
        logic [11:0] rgb;
        logic        hb;
        logic        vb;
        logic        hs_n;
        logic        vs_n;
    } exp_t;

    logic        clk;
    logic        RESETn;
    logic        pix_ce;
    logic [6:0]  sp_pix, bg_pix, tx_pix;
    logic [2:0]  colbank;
    logic        layer_sela_n, layer_selb_n;
    logic        hblank, vblank, hsync_n, vsync_n;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [11:0] cpu_din;
    logic        cpu_busy;
    logic [11:0] rgb;
    logic        hblank_o, vblank_o, hsync_no, vsync_no;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    final_mix_palette dut (
        .clk          (clk),
        .RESETn       (RESETn),
        .pix_ce       (pix_ce),
        .sp_pix       (sp_pix),
        .bg_pix       (bg_pix),
        .tx_pix       (tx_pix),
        .colbank      (colbank),
        .layer_sela_n (layer_sela_n),
        .layer_selb_n (layer_selb_n),
        .hblank       (hblank),
        .vblank       (vblank),
        .hsync_n      (hsync_n),
        .vsync_n      (vsync_n),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_din      (cpu_din),
        .cpu_busy     (cpu_busy),
        .rgb          (rgb),
        .hblank_o     (hblank_o),
        .vblank_o     (vblank_o),
        .hsync_no     (hsync_no),
        .vsync_no     (vsync_no)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rgb"},  32'(rgb), 32'h0);
        check({tag, "_hb"},   32'(hblank_o), 32'h1);
        check({tag, "_vb"},   32'(vblank_o), 32'h1);
        check({tag, "_hs"},   32'(hsync_no), 32'h1);
        check({tag, "_vs"},   32'(vsync_no), 32'h1);
    endtask

    task automatic drive_vec(input vec_t v);
        sp_pix       = v.sp;
        bg_pix       = v.bg;
        tx_pix       = v.tx;
        colbank      = v.bank;
        layer_selb_n = v.selb_n;
        layer_sela_n = v.sela_n;
        hblank       = v.hb;
        vblank       = v.vb;
        hsync_n      = v.hs_n;
        vsync_n      = v.vs_n;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.rgb  = v.exp_rgb;
        e.hb   = v.hb;
        e.vb   = v.vb;
        e.hs_n = v.hs_n;
        e.vs_n = v.vs_n;
        sb.push_back(e);
    endtask

    // Called half a clock after a pix_ce edge: once three pixels are in
    // flight the oldest is at the output; before that the output must still
    // show the post-reset idle state.
    task automatic check_outputs();
        exp_t e;
        if (sb.size() >= 3) begin
            e = sb.pop_front();
            check("pix_rgb", 32'(rgb), 32'(e.rgb));
            check("pix_hb",  32'(hblank_o), 32'(e.hb));
            check("pix_vb",  32'(vblank_o), 32'(e.vb));
            check("pix_hs",  32'(hsync_no), 32'(e.hs_n));
            check("pix_vs",  32'(vsync_no), 32'(e.vs_n));
        end else begin
            check_idle("fill");
        end
    endtask

    task automatic pixel(input vec_t v, input bit wr, input logic [9:0] wa, input logic [11:0] wd);
        @(negedge clk);
        drive_vec(v);
        pix_ce   = 1'b1;
        cpu_we   = wr;
        cpu_addr = wa;
        cpu_din  = wd;
        push_exp(v);
        @(negedge clk);
        pix_ce = 1'b0;
        cpu_we = 1'b0;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic pal_write(input logic [9:0] a, input logic [11:0] d);
        @(negedge clk);
        pix_ce   = 1'b0;
        cpu_we   = 1'b1;
        cpu_addr = a;
        cpu_din  = d;
        @(negedge clk);
        cpu_we = 1'b0;
        @(negedge clk);
    endtask

    function automatic vec_t mkv(input logic [6:0] sp, input logic [6:0] bg, input logic [6:0] tx,
                                 input logic [2:0] bank, input logic [1:0] sel,
                                 input logic hb, input logic vb, input logic hs_n, input logic vs_n,
                                 input logic [11:0] exp_rgb);
        vec_t v;
        v.sp = sp; v.bg = bg; v.tx = tx; v.bank = bank;
        v.selb_n = sel[1]; v.sela_n = sel[0];
        v.hb = hb; v.vb = vb; v.hs_n = hs_n; v.vs_n = vs_n;
        v.exp_rgb = exp_rgb;
        return v;
    endfunction

    localparam logic [11:0] SHADOW_EXP =
`ifdef FINAL_MIX_SHADOW_EN
        12'h777;
`else
        12'h246;
`endif

    vec_t vecs[12];
    vec_t blank_v;

    initial begin
        // Index = {bank, code}; expected colours are the palette words
        // written below at those hand-computed addresses.
        vecs[0]  = mkv(7'h25, 7'h00, 7'h00, 3'd5, 2'b00, 0, 0, 1, 1, 12'hF80); // 0x2A5 sprite
        vecs[1]  = mkv(7'h1F, 7'h11, 7'h00, 3'd0, 2'b00, 0, 0, 1, 1, 12'h0F0); // transparent -> bg 0x011
        vecs[2]  = mkv(7'h1F, 7'h11, 7'h00, 3'd0, 2'b00, 1, 0, 1, 1, 12'h000); // hblank
        vecs[3]  = mkv(7'h0F, 7'h00, 7'h33, 3'd2, 2'b01, 0, 0, 1, 1, 12'h3C1); // text 0x133
        vecs[4]  = mkv(7'h25, 7'h00, 7'h00, 3'd0, 2'b10, 0, 0, 0, 1, 12'h123); // text 0x000, hsync
        vecs[5]  = mkv(7'h25, 7'h7F, 7'h00, 3'd7, 2'b11, 0, 0, 1, 0, 12'h5A5); // bg 0x3FF, vsync
        vecs[6]  = mkv(7'h6F, 7'h40, 7'h00, 3'd1, 2'b00, 0, 0, 1, 1, 12'h9E1); // transparent -> bg 0x0C0
        vecs[7]  = mkv(7'h25, 7'h00, 7'h00, 3'd0, 2'b00, 0, 0, 1, 1, 12'h6B6); // sprite 0x025
        vecs[8]  = mkv(7'h7E, 7'h10, 7'h00, 3'd3, 2'b00, 0, 0, 1, 1, SHADOW_EXP); // shadow / 0x1FE
        vecs[9]  = mkv(7'h25, 7'h00, 7'h00, 3'd5, 2'b00, 0, 1, 1, 1, 12'h000); // vblank
        vecs[10] = mkv(7'h00, 7'h01, 7'h00, 3'd2, 2'b11, 0, 0, 1, 1, 12'h3C3); // 0x101 worst-case write
        vecs[11] = mkv(7'h00, 7'h00, 7'h00, 3'd2, 2'b11, 0, 0, 1, 1, 12'hABC); // 0x100 first write kept
        blank_v  = mkv(7'h00, 7'h00, 7'h00, 3'd0, 2'b11, 1, 1, 1, 1, 12'h000);

        RESETn = 1'b0;
        pix_ce = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_din  = '0;
        drive_vec(blank_v);

        // Reset state.
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_busy", 32'(cpu_busy), 32'h0);
        RESETn = 1'b1;

        pal_write(10'h2A5, 12'hF80);
        pal_write(10'h011, 12'h0F0);
        pal_write(10'h133, 12'h3C1);
        pal_write(10'h000, 12'h123);
        pal_write(10'h3FF, 12'h5A5);
        pal_write(10'h0C0, 12'h9E1);
        pal_write(10'h025, 12'h6B6);
        pal_write(10'h190, 12'hEEE);
        pal_write(10'h1FE, 12'h246);
        pal_write(10'h155, 12'h111);
        pal_write(10'h2AA, 12'h0A0);

        // Write accepted, second request while busy dropped, busy one cycle.
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 10'h100; cpu_din = 12'hABC;
        @(negedge clk);
        check("wr_busy_t1", 32'(cpu_busy), 32'h1);
        cpu_addr = 10'h100; cpu_din = 12'h555;
        @(negedge clk);
        check("wr_busy_t2", 32'(cpu_busy), 32'h0);
        cpu_we = 1'b0;
        @(negedge clk);
        check("wr_drop_busy", 32'(cpu_busy), 32'h0);

        // Worst case: pix_ce the cycle after the request delays the commit.
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 10'h101; cpu_din = 12'h3C3;
        @(negedge clk);
        check("wc_busy_t1", 32'(cpu_busy), 32'h1);
        cpu_we = 1'b0;
        drive_vec(blank_v);
        pix_ce = 1'b1;
        push_exp(blank_v);
        @(negedge clk);
        pix_ce = 1'b0;
        check_outputs();
        check("wc_busy_t2", 32'(cpu_busy), 32'h1);
        @(negedge clk);
        check("wc_busy_t3", 32'(cpu_busy), 32'h0);

        // Table-driven pixels.
        for (int i = 0; i < 12; i++) begin
            pixel(vecs[i], 1'b0, 10'h0, 12'h0);
        end

        // Same-address read then write: read during the write's accept slot
        // returns old data, the next read sees the new word.
        pixel(mkv(7'h00, 7'h55, 7'h00, 3'd2, 2'b11, 0, 0, 1, 1, 12'h111), 1'b0, 10'h0, 12'h0);
        pixel(blank_v, 1'b1, 10'h155, 12'h222);
        pixel(mkv(7'h00, 7'h55, 7'h00, 3'd2, 2'b11, 0, 0, 1, 1, 12'h222), 1'b0, 10'h0, 12'h0);
        pixel(vecs[0], 1'b0, 10'h0, 12'h0);
        pixel(vecs[0], 1'b0, 10'h0, 12'h0);

        // Reset mid-frame with a write still pending: write is discarded.
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 10'h2AA; cpu_din = 12'hDEF;
        @(negedge clk);
        cpu_we = 1'b0;
        drive_vec(vecs[0]);
        pix_ce = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0;
        check("rst_pend_busy", 32'(cpu_busy), 32'h1);
        check("rst_pre_rgb", 32'(rgb), 32'hF80);
        #2 RESETn = 1'b0;
        #1;
        check_idle("midrst");
        check("midrst_busy", 32'(cpu_busy), 32'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        RESETn = 1'b1;

        // First pixel after reset emerges on the third pix_ce.
        for (int i = 0; i < 3; i++) begin
            pixel(mkv(7'h2A, 7'h00, 7'h00, 3'd5, 2'b00, 0, 0, 1, 1, 12'h0A0), 1'b0, 10'h0, 12'h0);
        end
        for (int i = 0; i < 2; i++) begin
            pixel(blank_v, 1'b0, 10'h0, 12'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
